// File: rtl/vga_timing_generator_if.sv
// Video timing bundle: pixel-clock enable in, raster position plus delayed sync/enable/strobes out.
interface vga_timing_generator_if #(
   parameter int CNT_W = 11
);
   logic             enable;
   logic [CNT_W-1:0] pixel_x;
   logic [CNT_W-1:0] pixel_y;
   logic             in_display_area;
   logic             hw_vga_h_sync;
   logic             hw_vga_v_sync;
   logic             line_start;
   logic             frame_start;

   modport master (
      input  enable,
      output pixel_x, pixel_y, in_display_area,
      output hw_vga_h_sync, hw_vga_v_sync, line_start, frame_start
   );

   modport slave (
      output enable,
      input  pixel_x, pixel_y, in_display_area,
      input  hw_vga_h_sync, hw_vga_v_sync, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster timing: x/y pixel counters plus sync, display-enable and line/frame
// strobes, delayed by PIPE_DELAY enabled cycles to line up with fetched pixel data.
module vga_timing_generator #(
   parameter int X_RES         = 640,
   parameter int Y_RES         = 480,
   parameter int H_FRONT_PORCH = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BACK_PORCH  = 48,
   parameter int V_FRONT_PORCH = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BACK_PORCH  = 33,
   parameter bit H_SYNC_POL    = 1'b0,
   parameter bit V_SYNC_POL    = 1'b0,
   parameter int PIPE_DELAY    = 0,
   parameter int CNT_W         = 11
) (
   input  logic                   clk25,
   input  logic                   rst_n,
   vga_timing_generator_if.master vga
);
   localparam int H_TOTAL  = X_RES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
   localparam int V_TOTAL  = Y_RES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
   localparam int HS_BEGIN = X_RES + H_FRONT_PORCH;
   localparam int HS_END   = X_RES + H_FRONT_PORCH + H_SYNC;
   localparam int VS_BEGIN = Y_RES + V_FRONT_PORCH;
   localparam int VS_END   = Y_RES + V_FRONT_PORCH + V_SYNC;

   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

   // Bundle order {de, h_sync, v_sync, line_start, frame_start}; idle = syncs at inactive level.
   localparam logic [4:0] IDLE = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL, 2'b00};

   logic [CNT_W-1:0] r_x;
   logic [CNT_W-1:0] r_y;

   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (vga.enable) begin
         if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   logic       w_de;
   logic       w_hs_act;
   logic       w_vs_act;
   logic       w_line_start;
   logic       w_frame_start;
   logic [4:0] w_decode;
   logic [4:0] w_out;

   assign w_de          = (r_x < CNT_W'(X_RES)) && (r_y < CNT_W'(Y_RES));
   assign w_hs_act      = (r_x >= CNT_W'(HS_BEGIN)) && (r_x < CNT_W'(HS_END));
   // Vertical sync spans whole lines, so it only changes when x wraps to 0.
   assign w_vs_act      = (r_y >= CNT_W'(VS_BEGIN)) && (r_y < CNT_W'(VS_END));
   assign w_line_start  = (r_x == '0);
   assign w_frame_start = w_line_start && (r_y == '0);

   assign w_decode = {w_de,
                      w_hs_act ? H_SYNC_POL : ~H_SYNC_POL,
                      w_vs_act ? V_SYNC_POL : ~V_SYNC_POL,
                      w_line_start,
                      w_frame_start};

   generate
      if (PIPE_DELAY == 0) begin : g_no_pipe
         assign w_out = w_decode;
      end else begin : g_pipe
         logic [4:0] r_stage [PIPE_DELAY];

         always_ff @(posedge clk25) begin
            if (!rst_n) begin
               for (int i = 0; i < PIPE_DELAY; i++) begin
                  r_stage[i] <= IDLE;
               end
            end else if (vga.enable) begin
               r_stage[0] <= w_decode;
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign w_out = r_stage[PIPE_DELAY-1];
      end
   endgenerate

   assign vga.pixel_x         = r_x;
   assign vga.pixel_y         = r_y;
   assign vga.in_display_area = w_out[4];
   assign vga.hw_vga_h_sync   = w_out[3];
   assign vga.hw_vga_v_sync   = w_out[2];
   assign vga.line_start      = w_out[1];
   assign vga.frame_start     = w_out[0];
endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: three timing generators (defaults, small raster, 2-stage pipe with
// positive h-sync) checked against hand-computed (cycle, x, y, flags) vectors.
module tb_vga_timing_generator;
   logic clk25 = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk25 = ~clk25;
   always @(posedge clk25) cyc <= cyc + 1;

   vga_timing_generator_if #(.CNT_W(11)) a_if ();
   vga_timing_generator_if #(.CNT_W(11)) b_if ();
   vga_timing_generator_if #(.CNT_W(11)) c_if ();
   assign a_if.enable = en;
   assign b_if.enable = en;
   assign c_if.enable = en;

   // A: 640x480@60 defaults
   vga_timing_generator dut_a (.clk25(clk25), .rst_n(rst_n), .vga(a_if));

   // B: 16 x 8 raster; h-sync x 10..12, v-sync y 5..6
   vga_timing_generator #(
      .X_RES(8), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(3),
      .Y_RES(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1)
   ) dut_b (.clk25(clk25), .rst_n(rst_n), .vga(b_if));

   // C: default horizontal timing, 8-line frame, 2-cycle pipe, active-high h-sync
   vga_timing_generator #(
      .Y_RES(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1),
      .H_SYNC_POL(1'b1), .PIPE_DELAY(2)
   ) dut_c (.clk25(clk25), .rst_n(rst_n), .vga(c_if));

   // Flags are {de, h_sync, v_sync, line_start, frame_start}; m masks which flags are checked.
   typedef struct {
      int          cyc;
      logic [10:0] x;
      logic [10:0] y;
      logic [4:0]  f;
      logic [4:0]  m;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];
   exp_t e_a, e_b, e_c;

   task automatic push(input int d, input int c, input int x, input int y,
                       input logic [4:0] f, input logic [4:0] m);
      exp_t e;
      e.cyc = c;
      e.x   = 11'(x);
      e.y   = 11'(y);
      e.f   = f;
      e.m   = m;
      case (d)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   task automatic check(input string name, input exp_t e, input int now,
                        input logic [10:0] ax, input logic [10:0] ay, input logic [4:0] af);
      checks++;
      if (e.cyc != now || ax !== e.x || ay !== e.y || (af & e.m) !== (e.f & e.m)) begin
         errors++;
         $display("FAIL %s cyc %0d: actual x=%0d y=%0d flags=%b, required cyc %0d x=%0d y=%0d flags=%b mask=%b",
                  name, now, ax, ay, af, e.cyc, e.x, e.y, e.f, e.m);
      end else begin
         $display("ok   %s cyc %0d: x=%0d y=%0d flags=%b", name, now, ax, ay, af);
      end
   endtask

   always @(negedge clk25) begin
      while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
         e_a = q_a.pop_front();
         check("dut_a", e_a, cyc, a_if.pixel_x, a_if.pixel_y,
               {a_if.in_display_area, a_if.hw_vga_h_sync, a_if.hw_vga_v_sync,
                a_if.line_start, a_if.frame_start});
      end
   end

   always @(negedge clk25) begin
      while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
         e_b = q_b.pop_front();
         check("dut_b", e_b, cyc, b_if.pixel_x, b_if.pixel_y,
               {b_if.in_display_area, b_if.hw_vga_h_sync, b_if.hw_vga_v_sync,
                b_if.line_start, b_if.frame_start});
      end
   end

   always @(negedge clk25) begin
      while (q_c.size() > 0 && q_c[0].cyc <= cyc) begin
         e_c = q_c.pop_front();
         check("dut_c", e_c, cyc, c_if.pixel_x, c_if.pixel_y,
               {c_if.in_display_area, c_if.hw_vga_h_sync, c_if.hw_vga_v_sync,
                c_if.line_start, c_if.frame_start});
      end
   end

   // Returns just after the posedge that makes cyc == c.
   task automatic at(input int c);
      while (cyc < c) begin
         @(posedge clk25);
         #1;
      end
   endtask

   int r1, r2, r4, r5;

   initial begin
      // Free-running from reset: three reset edges (cycles 1..3), released for posedge 4.
      r1 = 3;
      push(0, 2, 0, 0, 5'b01100, 5'b01100);
      push(0, r1+0,    0,   0, 5'b11111, 5'b11111);
      push(0, r1+1,    1,   0, 5'b11100, 5'b11111);
      push(0, r1+639,  639, 0, 5'b11100, 5'b11111);
      push(0, r1+640,  640, 0, 5'b01100, 5'b11111);
      push(0, r1+655,  655, 0, 5'b01100, 5'b11111);
      push(0, r1+656,  656, 0, 5'b00100, 5'b11111);
      push(0, r1+751,  751, 0, 5'b00100, 5'b11111);
      push(0, r1+752,  752, 0, 5'b01100, 5'b11111);
      push(0, r1+799,  799, 0, 5'b01100, 5'b11111);
      push(0, r1+800,  0,   1, 5'b11110, 5'b11111);
      push(0, r1+1456, 656, 1, 5'b00100, 5'b11111);
      push(0, r1+1599, 799, 1, 5'b01100, 5'b11111);

      push(1, 2, 0, 0, 5'b00000, 5'b00000);
      push(1, r1+0,   0,  0, 5'b11111, 5'b11111);
      push(1, r1+7,   7,  0, 5'b11100, 5'b11111);
      push(1, r1+8,   8,  0, 5'b01100, 5'b11111);
      push(1, r1+10,  10, 0, 5'b00100, 5'b11111);
      push(1, r1+12,  12, 0, 5'b00100, 5'b11111);
      push(1, r1+13,  13, 0, 5'b01100, 5'b11111);
      push(1, r1+15,  15, 0, 5'b01100, 5'b11111);
      push(1, r1+16,  0,  1, 5'b11110, 5'b11111);
      push(1, r1+64,  0,  4, 5'b01110, 5'b11111);
      push(1, r1+80,  0,  5, 5'b01010, 5'b11111);
      push(1, r1+111, 15, 6, 5'b01000, 5'b11111);
      push(1, r1+112, 0,  7, 5'b01110, 5'b11111);
      push(1, r1+127, 15, 7, 5'b01100, 5'b11111);
      push(1, r1+128, 0,  0, 5'b11111, 5'b11111);
      push(1, r1+256, 0,  0, 5'b11111, 5'b11111);

      push(2, 2, 0, 0, 5'b00100, 5'b11111);
      push(2, r1+0,   0,   0, 5'b00100, 5'b11111);
      push(2, r1+1,   1,   0, 5'b00100, 5'b11111);
      push(2, r1+2,   2,   0, 5'b10111, 5'b11111);
      push(2, r1+3,   3,   0, 5'b10100, 5'b11111);
      push(2, r1+641, 641, 0, 5'b10100, 5'b11111);
      push(2, r1+642, 642, 0, 5'b00100, 5'b11111);
      push(2, r1+657, 657, 0, 5'b00100, 5'b11111);
      push(2, r1+658, 658, 0, 5'b01100, 5'b11111);
      push(2, r1+753, 753, 0, 5'b01100, 5'b11111);
      push(2, r1+754, 754, 0, 5'b00100, 5'b11111);
      push(2, r1+801, 1,   1, 5'b00100, 5'b11111);
      push(2, r1+802, 2,   1, 5'b10110, 5'b11111);

      rst_n = 1'b0;
      en    = 1'b1;
      at(r1);
      rst_n = 1'b1;

      // Enable gated 1-in-4: one reset edge, then only every fourth posedge advances.
      at(r1+1700);
      rst_n = 1'b0;
      at(r1+1701);
      r2 = cyc;
      rst_n = 1'b1;
      en    = 1'b0;
      push(0, r2+0,    0,   0, 5'b11111, 5'b11111);
      push(0, r2+3,    0,   0, 5'b11111, 5'b11111);
      push(0, r2+4,    1,   0, 5'b11100, 5'b11111);
      push(0, r2+6,    1,   0, 5'b11100, 5'b11111);
      push(0, r2+2560, 640, 0, 5'b01100, 5'b11111);
      push(0, r2+2624, 656, 0, 5'b00100, 5'b11111);
      push(0, r2+3199, 799, 0, 5'b01100, 5'b11111);
      push(0, r2+3200, 0,   1, 5'b11110, 5'b11111);
      push(0, r2+3203, 0,   1, 5'b11110, 5'b11111);
      push(0, r2+3204, 1,   1, 5'b11100, 5'b11111);
      push(0, r2+6400, 0,   2, 5'b11110, 5'b11111);
      for (int k = r2; k < r2 + 6420; k++) begin
         at(k);
         en = ((k - r2) % 4 == 3);
      end

      // Free-running again, then a single-edge reset mid-frame.
      at(r2+6420);
      rst_n = 1'b0;
      en    = 1'b1;
      at(r2+6421);
      r4 = cyc;
      r5 = r4 + 4301;
      rst_n = 1'b1;
      push(0, r4+4300, 300, 5, 5'b11100, 5'b11111);
      push(0, r5,      0,   0, 5'b11111, 5'b11111);
      push(1, r4+4300, 12,  4, 5'b00100, 5'b11111);
      push(1, r5,      0,   0, 5'b11111, 5'b11111);
      push(2, r4+4300, 300, 5, 5'b00000, 5'b11111);
      push(2, r5,      0,   0, 5'b00100, 5'b11111);
      push(2, r5+1,    1,   0, 5'b00100, 5'b11111);
      push(2, r5+2,    2,   0, 5'b10111, 5'b11111);
      at(r4+4300);
      rst_n = 1'b0;
      at(r5);
      rst_n = 1'b1;
      at(r5+10);
      @(negedge clk25);
      #1;

      checks++;
      if (q_a.size() + q_b.size() + q_c.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: actual %0d expectations left, required 0",
                  q_a.size() + q_b.size() + q_c.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
